// File: rtl/pong_pkg.sv
// Shared pong datapath definitions: FSM state, field geometry and the
// saturating single-cell move helper.
package pong_pkg;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam int POS_W = 3;
  localparam logic [POS_W-1:0] POS_MIN    = 3'd0;
  localparam logic [POS_W-1:0] POS_MAX    = 3'd7;
  localparam logic [POS_W-1:0] PADDLE_ROW = 3'd6;
  localparam logic [POS_W-1:0] END_ROW    = 3'd7;

  // One cell toward dir (0 = +1, 1 = -1), clamped to [POS_MIN, hi].
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p,
                                                input logic             dir,
                                                input logic [POS_W-1:0] hi);
    logic [POS_W-1:0] r;
    r = p;
    if (dir) begin
      if (p != POS_MIN) r = p - 1'b1;
    end else begin
      if (p != hi) r = p + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/move_tick.sv
// Reloadable down-counter: tick fires while enabled with count at zero,
// and the same edge reloads period-1.
module move_tick #(
  parameter int CW      = 4,
  parameter int RST_VAL = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] period,
  output logic          tick
);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= CW'(RST_VAL);
    else if (load || tick) cnt <= period - 1'b1;
    else if (en)           cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/ball_motion.sv
// Ball position stage: IDLE/RUN/OVER FSM stepping a saturating (x,y) once per
// period. Define BALL_SPEEDUP_EN to shorten the period on each paddle hit.
module ball_motion
  import pong_pkg::*;
#(
  parameter int MOVE_DIV = 8,
  parameter int START_X  = 3,
  parameter int START_Y  = 1,
  parameter int MIN_DIV  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir_x,
  input  logic             dir_y,
  input  logic             endgame,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             running,
  output logic             game_over,
  output logic             step
);

  localparam int CW = $clog2(MOVE_DIV + 1);

  state_t        state, state_nxt;
  logic          tick, move, load, hit;
  logic [CW-1:0] period, period_nxt;

  assign load = start && (state != RUN);
  assign move = tick && !endgame;
  assign hit  = move && (y_pos == PADDLE_ROW) && dir_y;

`ifdef BALL_SPEEDUP_EN
  // Counter reloads from period_nxt so a hit already shortens the next interval.
  always_comb begin
    period_nxt = period;
    if (load)                           period_nxt = CW'(MOVE_DIV);
    else if (hit && period > CW'(MIN_DIV)) period_nxt = period - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) period <= CW'(MOVE_DIV);
    else        period <= period_nxt;
  end
`else
  assign period     = CW'(MOVE_DIV);
  assign period_nxt = period;
`endif

  move_tick #(.CW(CW), .RST_VAL(MOVE_DIV - 1)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == RUN),
    .load   (load),
    .period (period_nxt),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = RUN;
      RUN:     if (endgame) state_nxt = OVER;
      OVER:    if (start)   state_nxt = RUN;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running   = (state == RUN);
    game_over = (state == OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos <= POS_W'(START_X);
      y_pos <= POS_W'(START_Y);
      step  <= 1'b0;
    end else begin
      step <= move;
      if (load) begin
        x_pos <= POS_W'(START_X);
        y_pos <= POS_W'(START_Y);
      end else if (move) begin
        x_pos <= step_pos(x_pos, dir_x, POS_MAX);
        y_pos <= step_pos(y_pos, dir_y, END_ROW);
      end
    end
  end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Sequential ball-position stage of the pong datapath.
- Holds the ball's 3-bit (x, y) position on the 8x8 field and steps it one cell per move tick.
- Each step uses the direction bits and endgame flag from the combinational vector calculator.
- Its x_pos/y_pos outputs feed the vector calculator and the display logic, closing the position/direction loop.

Parameters:
- MOVE_DIV, 8, clock cycles per ball step; legal range 2..255.
- START_X, 3, x position loaded at reset and on restart.
- START_Y, 1, y position loaded at reset and on restart.
- MIN_DIV, 2, lowest step period reachable with speed-up (feature only).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: asynchronous, active-low.
- start  input  1  one-cycle pulse; starts or restarts a game.
- dir_x  input  1  x direction from vector calc: 0 = +1, 1 = -1.
- dir_y  input  1  y direction from vector calc: 0 = +1, 1 = -1.
- endgame  input  1  ball missed paddle; terminate the game.
- x_pos  output  3  current ball x.
- y_pos  output  3  current ball y.
- running  output  1  high in RUN.
- game_over  output  1  high in OVER.
- step  output  1  one-cycle pulse on the cycle a move is applied.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, x_pos=START_X, y_pos=START_Y.
  - running=0, game_over=0, step=0.
  - divider count=MOVE_DIV-1.
- FSM states:
  - IDLE: start -> RUN, and the divider reloads to MOVE_DIV-1.
  - RUN:
    - endgame=1 -> OVER.
    - start is ignored.
    - The divider decrements every cycle.
    - When the count is 0 and endgame=0: apply the move, pulse step, reload to the current period-1.
  - OVER:
    - Position is frozen; game_over=1.
    - start -> RUN with x_pos=START_X, y_pos=START_Y, divider reloaded, speed-up period reset.
- Move arithmetic:
  - x_next = x_pos + 1 if dir_x=0, else x_pos - 1; y uses the same rule with dir_y.
  - Saturate at 0 and 7; never wrap. (x=7 with dir_x=0 stays 7; x=0 with dir_x=1 stays 0.)
- Sampling and latency:
  - dir_x/dir_y are sampled on the move edge only.
  - The new position is visible one cycle after the cycle where the count is 0, coincident with step=1.
  - The first move happens MOVE_DIV cycles after start is seen.
- Simultaneous events:
  - endgame and a move tick in the same cycle: endgame wins, no move, no step.
  - endgame is ignored outside RUN.
- Outputs are registered: running = (state==RUN), game_over = (state==OVER).
- Reset mid-game returns everything to the reset values immediately.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined:
  - A paddle hit is a move where y_pos was 6 and the sampled dir_y=1.
  - Each paddle hit decrements the active period by 1, floored at MIN_DIV.
  - The period returns to MOVE_DIV on restart or reset.
- Undefined: the period is constant at MOVE_DIV; MIN_DIV is unused.

Decomposition:
- Shared package pong_pkg holds:
  - the state enum (IDLE, RUN, OVER);
  - POS_W=3, POS_MIN=0, POS_MAX=7;
  - PADDLE_ROW=6, END_ROW=7.
- Sub-module move_tick:
  - a reloadable down-counter with en, load, period inputs and a tick output;
  - instantiated once;
  - counter width = $clog2(MOVE_DIV+1).

Test Plan (MOVE_DIV=4 unless noted):
- Reset, then idle for 20 cycles -> x=3, y=1, running=0, no step pulses.
- start pulse, dir_x=0, dir_y=0 -> step every 4 cycles; positions (4,2), (5,3), (6,4).
- x=7 with dir_x=0 held for 3 steps -> x stays 7, and y keeps stepping.
- endgame asserted in the same cycle as a tick -> no step, next cycle game_over=1, position unchanged; a later start gives (3,1) and running=1.
- Async reset pulse mid-RUN between clock edges -> outputs return to reset values before the next edge.
- With BALL_SPEEDUP_EN and MOVE_DIV=5, MIN_DIV=3: four paddle hits -> step spacing 5 -> 4 -> 3 -> 3 -> 3 cycles.
